// File: rtl/serial_sub_if.sv
// Handshake and result bundle for the bit-serial subtractor.
// master drives requests (operands, start); slave is the subtractor.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             Bout;
    logic             V;

    modport master (
        output start, A, B, Bin,
        input  busy, done, diff, Bout, V
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, diff, Bout, V
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial ripple subtractor: diff = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell with one borrow flop; results are held between operations.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    serial_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, sd;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             msb_a, msb_b;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q, v_q;

    logic             accept, last;
    logic             a, b, d, br_nxt;
    logic [WIDTH-1:0] sd_nxt;

    // start only counts when the unit is not mid-operation
    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    assign a      = sa[0];
    assign b      = sb[0];
    assign d      = a ^ b ^ br;
    assign br_nxt = (~a & b) | (~(a ^ b) & br);
    assign sd_nxt = {d, sd[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            msb_a  <= 1'b0;
            msb_b  <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            v_q    <= 1'b0;
        end else if (accept) begin
            sa    <= bus.A;
            sb    <= bus.B;
            sd    <= '0;
            br    <= bus.Bin;
            cnt   <= '0;
            msb_a <= bus.A[WIDTH-1];
            msb_b <= bus.B[WIDTH-1];
        end else if (state == RUN) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
            sd <= sd_nxt;
            br <= br_nxt;
            if (last) begin
                // d is the result MSB on the final bit
                diff_q <= sd_nxt;
                bout_q <= br_nxt;
                v_q    <= (msb_a != msb_b) && (d != msb_a);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_q;
    assign bus.Bout = bout_q;
    assign bus.V    = v_q;
endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks of serial_sub against an arithmetic reference model.
module tb_serial_sub;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(W)) bus ();
    serial_sub #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                  output logic [W-1:0] d, output logic bo, output logic v);
        longint ua, ub, r, s_a, s_b, rs;
        ua  = longint'(a);
        ub  = longint'(b);
        r   = ua - ub - longint'(bin);
        d   = r[W-1:0];
        bo  = (r < 0);
        s_a = a[W-1] ? ua - (longint'(1) << W) : ua;
        s_b = b[W-1] ? ub - (longint'(1) << W) : ub;
        rs  = s_a - s_b - longint'(bin);
        v   = (rs > (longint'(1) << (W - 1)) - 1) || (rs < -(longint'(1) << (W - 1)));
    endfunction

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        bus.Bin   = 1'($urandom);
    endtask

    // Counts edges after the accepting edge until done; optionally pulses start mid-run.
    task automatic wait_done(input int glitch_at, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (bus.done !== 1'b1 && lat < 3 * W) begin
            if (bus.busy === 1'b1) bcnt++;
            if (lat == glitch_at) begin
                bus.start = 1'b1;
                bus.A     = W'($urandom);
                bus.B     = W'($urandom);
            end
            step();
            bus.start = 1'b0;
            lat++;
        end
    endtask

    task automatic check_op(input string tag, input int lat, input int bcnt,
                            input logic [W-1:0] ed, input logic eb, input logic ev);
        chk({tag, ".latency"}, 32'(lat), 32'(W));
        chk({tag, ".busy_cycles"}, 32'(bcnt), 32'(W));
        chk({tag, ".done"}, 32'(bus.done), 32'(1));
        chk({tag, ".busy_at_done"}, 32'(bus.busy), 32'(0));
        chk({tag, ".diff"}, 32'(bus.diff), 32'(ed));
        chk({tag, ".Bout"}, 32'(bus.Bout), 32'(eb));
        chk({tag, ".V"}, 32'(bus.V), 32'(ev));
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         bin;
        logic [W-1:0] ed;
        logic         eb, ev;
    } vec_t;

    initial begin
        vec_t         dir[5];
        int           lat, bcnt, pulses;
        logic [W-1:0] md, ra, rb;
        logic         mb, mv, rbin;

        dir[0] = '{8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0};
        dir[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        dir[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        dir[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        dir[4] = '{8'h0F, 8'h0F, 1'b1, 8'hFF, 1'b1, 1'b0};

        // reset with start held high: reset must win
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.A     = 8'h55;
        bus.B     = 8'h11;
        bus.Bin   = 1'b0;
        step();
        step();
        chk("reset.busy", 32'(bus.busy), 0);
        chk("reset.done", 32'(bus.done), 0);
        chk("reset.diff", 32'(bus.diff), 0);
        chk("reset.Bout", 32'(bus.Bout), 0);
        chk("reset.V", 32'(bus.V), 0);
        bus.start = 1'b0;
        rst       = 1'b0;
        step();

        foreach (dir[i]) begin
            launch(dir[i].a, dir[i].b, dir[i].bin);
            wait_done(-1, lat, bcnt);
            check_op($sformatf("dir%0d", i), lat, bcnt, dir[i].ed, dir[i].eb, dir[i].ev);
            step();
            chk($sformatf("dir%0d.done_pulse", i), 32'(bus.done), 0);
            chk($sformatf("dir%0d.diff_held", i), 32'(bus.diff), 32'(dir[i].ed));
        end

        // start pulsed in RUN with other operands is ignored
        launch(8'h50, 8'h30, 1'b0);
        wait_done(3, lat, bcnt);
        check_op("ignore", lat, bcnt, 8'h20, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < W + 2; i++) begin
            step();
            if (bus.done === 1'b1) pulses++;
        end
        chk("ignore.extra_done", 32'(pulses), 0);

        // back-to-back: start held through DONE
        launch(8'h12, 8'h34, 1'b0);
        wait_done(-1, lat, bcnt);
        check_op("b2b_first", lat, bcnt, 8'hDE, 1'b1, 1'b0);
        bus.A     = 8'h7F;
        bus.B     = 8'hFF;
        bus.Bin   = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("b2b.busy_no_idle", 32'(bus.busy), 1);
        chk("b2b.done_low", 32'(bus.done), 0);
        chk("b2b.diff_held_in_run", 32'(bus.diff), 32'(8'hDE));
        wait_done(-1, lat, bcnt);
        chk("b2b.done_spacing", 32'(lat + 1), 32'(W + 1));
        check_op("b2b_second", lat, bcnt, 8'h80, 1'b1, 1'b1);
        step();

        // reset during RUN cycle 5
        launch(8'h33, 8'h11, 1'b0);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        #1;
        chk("midrst.busy", 32'(bus.busy), 0);
        chk("midrst.done", 32'(bus.done), 0);
        chk("midrst.diff", 32'(bus.diff), 0);
        chk("midrst.Bout", 32'(bus.Bout), 0);
        chk("midrst.V", 32'(bus.V), 0);
        step();
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < W + 2; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
            step();
        end
        chk("midrst.no_activity", 32'(pulses), 0);
        launch(8'h05, 8'h03, 1'b0);
        wait_done(-1, lat, bcnt);
        check_op("after_rst", lat, bcnt, 8'h02, 1'b0, 1'b0);

        // random operations, randomly chained back-to-back or separated by IDLE
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) step();
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            model(ra, rb, rbin, md, mb, mv);
            launch(ra, rb, rbin);
            wait_done((i % 5 == 0) ? 2 : -1, lat, bcnt);
            check_op($sformatf("rnd%0d", i), lat, bcnt, md, mb, mv);
        end
        step();
        chk("final.done_low", 32'(bus.done), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
